calc_entry_ctrl: RTL and testbench

Keypad-entry sequencer directly upstream of the 6-bit ripple add/sub stage (module add). It collects operand A, operator and operand B, then drives A_DATA, B_DATA and SUB_SEL. B_DATA is already one's-complemented for subtraction, so the adder's carry-in completes the two's complement. It captures the adder's SUM_DATA and presents a sign/magnitude result for the display stage.

---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_key_arb.sv | 30 +++
 rtl/calc_entry_ctrl.sv | 166 ++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the keypad-entry sequencer: FSM states, key events,
// default datapath sizes.
package calc_pkg;

  localparam int WIDTH_DEF     = 6;
  localparam int DIGIT_MAX_DEF = 9;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_CALC = 2'd2,
    S_RES  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE = 3'd0,
    EV_DIG  = 3'd1,
    EV_ADD  = 3'd2,
    EV_SUB  = 3'd3,
    EV_EQ   = 3'd4,
    EV_CLR  = 3'd5
  } ev_t;

  // True for either operator key.
  function automatic logic ev_is_op(input ev_t ev);
    return (ev == EV_ADD) || (ev == EV_SUB);
  endfunction

endpackage

// File: rtl/calc_key_arb.sv
// Priority arbiter: collapses the key pulses into one event per cycle.
// CLR > EQ > SUB > ADD > digit; out-of-range digits produce no event.
module calc_key_arb
  import calc_pkg::*;
#(
  parameter int DIGIT_MAX = DIGIT_MAX_DEF
) (
  input  logic       key_dig_vld,
  input  logic [3:0] key_digit,
  input  logic       key_add,
  input  logic       key_sub,
  input  logic       key_eq,
  input  logic       key_clr,
  output ev_t        ev
);

  logic dig_ok;
  assign dig_ok = key_dig_vld && (32'(key_digit) <= DIGIT_MAX);

  // Highest-priority key wins; everything else in that cycle is dropped.
  always_comb begin
    ev = EV_NONE;
    if (key_clr)      ev = EV_CLR;
    else if (key_eq)  ev = EV_EQ;
    else if (key_sub) ev = EV_SUB;
    else if (key_add) ev = EV_ADD;
    else if (dig_ok)  ev = EV_DIG;
  end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad-entry sequencer in front of the ripple add/sub stage. Collects
// A, operator, B; drives the adder operands; captures SUM_DATA one cycle
// after '=' and presents a sign/magnitude result to the display.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DIGIT_MAX = DIGIT_MAX_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             KEY_DIG_VLD,
  input  logic [3:0]       KEY_DIGIT,
  input  logic             KEY_ADD,
  input  logic             KEY_SUB,
  input  logic             KEY_EQ,
  input  logic             KEY_CLR,
  input  logic [WIDTH-1:0] SUM_DATA,
  output logic [WIDTH-1:0] A_DATA,
  output logic [WIDTH-1:0] B_DATA,
  output logic             SUB_SEL,
  output logic             DONE,
  output logic [4:0]       DISP_VAL,
  output logic             DISP_NEG,
  output logic [1:0]       STATE
);

  ev_t              ev;
  state_t           state_q, state_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic             a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_neg;
  logic [WIDTH-1:0] a_ext, b_ext;
  logic             done_d;
  logic [4:0]       disp_d;
  logic             neg_d;

  calc_key_arb #(.DIGIT_MAX(DIGIT_MAX)) u_arb (
    .key_dig_vld (KEY_DIG_VLD),
    .key_digit   (KEY_DIGIT),
    .key_add     (KEY_ADD),
    .key_sub     (KEY_SUB),
    .key_eq      (KEY_EQ),
    .key_clr     (KEY_CLR),
    .ev          (ev)
  );

  // Next-state and register updates; CLR behaves exactly like reset.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_vld_d = a_vld_q;
    b_vld_d = b_vld_q;
    sub_d   = sub_q;
    res_d   = res_q;
    done_d  = 1'b0;
    if (ev == EV_CLR) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      a_vld_d = 1'b0;
      b_vld_d = 1'b0;
      sub_d   = 1'b0;
      res_d   = '0;
    end else begin
      case (state_q)
        S_A: begin
          if (ev == EV_DIG) begin
            a_d     = KEY_DIGIT;
            a_vld_d = 1'b1;
          end else if (ev_is_op(ev) && a_vld_q) begin
            sub_d   = (ev == EV_SUB);
            state_d = S_B;
          end
        end
        S_B: begin
          if (ev == EV_DIG) begin
            b_d     = KEY_DIGIT;
            b_vld_d = 1'b1;
          end else if (ev_is_op(ev)) begin
            sub_d = (ev == EV_SUB);
          end else if (ev == EV_EQ && b_vld_q) begin
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          // Operands have been stable since entry; take the adder result.
          res_d   = SUM_DATA;
          done_d  = 1'b1;
          state_d = S_RES;
        end
        S_RES: begin
          if (ev == EV_DIG) begin
            a_d     = KEY_DIGIT;
            a_vld_d = 1'b1;
            b_d     = '0;
            b_vld_d = 1'b0;
            sub_d   = 1'b0;
            state_d = S_A;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  assign res_neg = -res_d;
  assign a_ext   = {{(WIDTH-4){1'b0}}, a_d};
  assign b_ext   = {{(WIDTH-4){1'b0}}, b_d};

  // Display value follows the state being entered; S_CALC freezes it.
  always_comb begin
    disp_d = DISP_VAL;
    neg_d  = 1'b0;
    case (state_d)
      S_A:    disp_d = {1'b0, a_d};
      S_B:    disp_d = b_vld_d ? {1'b0, b_d} : 5'd0;
      S_CALC: disp_d = DISP_VAL;
      S_RES: begin
        neg_d  = res_d[WIDTH-1];
        disp_d = res_d[WIDTH-1] ? res_neg[4:0] : res_d[4:0];
      end
      default: disp_d = 5'd0;
    endcase
  end

  // State and registered outputs; RST wins over any in-flight capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      sub_q    <= 1'b0;
      res_q    <= '0;
      A_DATA   <= '0;
      B_DATA   <= '0;
      SUB_SEL  <= 1'b0;
      DONE     <= 1'b0;
      DISP_VAL <= 5'd0;
      DISP_NEG <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_vld_q  <= a_vld_d;
      b_vld_q  <= b_vld_d;
      sub_q    <= sub_d;
      res_q    <= res_d;
      A_DATA   <= a_ext;
      // One's complement here; the adder's carry-in (SUB_SEL) adds the 1.
      B_DATA   <= sub_d ? ~b_ext : b_ext;
      SUB_SEL  <= sub_d;
      DONE     <= done_d;
      DISP_VAL <= disp_d;
      DISP_NEG <= neg_d;
    end
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl with a behavioural 6-bit add/sub stage.
module tb_calc_entry_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       KEY_DIG_VLD = 1'b0;
  logic [3:0] KEY_DIGIT = 4'd0;
  logic       KEY_ADD = 1'b0, KEY_SUB = 1'b0, KEY_EQ = 1'b0, KEY_CLR = 1'b0;
  logic [5:0] SUM_DATA;
  logic [5:0] A_DATA, B_DATA;
  logic       SUB_SEL, DONE, DISP_NEG;
  logic [4:0] DISP_VAL;
  logic [1:0] STATE;

  int total = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  // Downstream adder: A + B + carry-in.
  assign SUM_DATA = A_DATA + B_DATA + {5'd0, SUB_SEL};

  calc_entry_ctrl dut (
    .CLK(CLK), .RST(RST),
    .KEY_DIG_VLD(KEY_DIG_VLD), .KEY_DIGIT(KEY_DIGIT),
    .KEY_ADD(KEY_ADD), .KEY_SUB(KEY_SUB), .KEY_EQ(KEY_EQ), .KEY_CLR(KEY_CLR),
    .SUM_DATA(SUM_DATA),
    .A_DATA(A_DATA), .B_DATA(B_DATA), .SUB_SEL(SUB_SEL), .DONE(DONE),
    .DISP_VAL(DISP_VAL), .DISP_NEG(DISP_NEG), .STATE(STATE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of keys, cross the edge, sample 1 time unit later.
  task automatic step(input bit dv, input logic [3:0] d, input bit ad,
                      input bit sb, input bit eq, input bit cl);
    KEY_DIG_VLD = dv; KEY_DIGIT = d; KEY_ADD = ad;
    KEY_SUB = sb; KEY_EQ = eq; KEY_CLR = cl;
    @(posedge CLK); #1;
    KEY_DIG_VLD = 0; KEY_DIGIT = 0; KEY_ADD = 0;
    KEY_SUB = 0; KEY_EQ = 0; KEY_CLR = 0;
  endtask

  task automatic dig(input logic [3:0] d); step(1, d, 0, 0, 0, 0); endtask
  task automatic idle();                   step(0, 0, 0, 0, 0, 0); endtask

  initial begin
    // Reset
    @(posedge CLK); @(posedge CLK); #1;
    chk("rst_state", STATE, 0);
    chk("rst_a", A_DATA, 0);
    chk("rst_b", B_DATA, 0);
    chk("rst_sub", SUB_SEL, 0);
    chk("rst_done", DONE, 0);
    chk("rst_disp", DISP_VAL, 0);
    chk("rst_neg", DISP_NEG, 0);
    RST = 0;

    // 7 + 5 = 12
    dig(7);
    chk("a7_disp", DISP_VAL, 7);
    step(0, 0, 1, 0, 0, 0);
    chk("add_state", STATE, 1);
    chk("add_disp_novld", DISP_VAL, 0);
    dig(5);
    chk("b5_disp", DISP_VAL, 5);
    step(0, 0, 0, 0, 1, 0);
    chk("eq_state_calc", STATE, 2);
    chk("eq_done_low", DONE, 0);
    chk("add_a_data", A_DATA, 6'b000111);
    chk("add_b_data", B_DATA, 6'b000101);
    chk("add_sub_sel", SUB_SEL, 0);
    chk("calc_disp_hold", DISP_VAL, 5);
    idle();
    chk("add_done", DONE, 1);
    chk("add_state_res", STATE, 3);
    chk("add_disp", DISP_VAL, 12);
    chk("add_neg", DISP_NEG, 0);
    idle();
    chk("add_done_pulse", DONE, 0);

    // 3 - 8 = -5, started from a digit in S_RES
    dig(3);
    chk("new_state", STATE, 0);
    chk("new_a", A_DATA, 3);
    step(0, 0, 0, 1, 0, 0);
    dig(8);
    step(0, 0, 0, 0, 1, 0);
    chk("sub_b_data", B_DATA, 6'b110111);
    chk("sub_sel", SUB_SEL, 1);
    idle();
    chk("sub_done", DONE, 1);
    chk("sub_neg", DISP_NEG, 1);
    chk("sub_disp", DISP_VAL, 5);
    chk("sub_state", STATE, 3);
    step(0, 0, 1, 0, 0, 0);
    chk("res_add_ignored", STATE, 3);

    // Out-of-range digit, operator without A, EQ without B
    step(0, 0, 0, 0, 0, 1);
    chk("clr_state", STATE, 0);
    chk("clr_b", B_DATA, 0);
    chk("clr_neg", DISP_NEG, 0);
    dig(12);
    chk("dig12_disp", DISP_VAL, 0);
    chk("dig12_a", A_DATA, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("add_no_a", STATE, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("eq_in_a", STATE, 0);
    dig(4);
    step(0, 0, 1, 0, 0, 0);
    chk("op_to_b", STATE, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("eq_no_b", STATE, 1);
    dig(15);
    chk("dig15_in_b", DISP_VAL, 0);
    dig(2);
    chk("b2_disp", DISP_VAL, 2);

    // EQ beats a same-cycle digit
    step(1, 6, 0, 0, 1, 0);
    chk("eq_wins_state", STATE, 2);
    chk("eq_wins_b", B_DATA, 6'b000010);
    idle();
    chk("eq_wins_done", DONE, 1);
    chk("eq_wins_disp", DISP_VAL, 6);

    // CLR beats a same-cycle EQ
    dig(1);
    step(0, 0, 1, 0, 0, 0);
    dig(1);
    step(0, 0, 0, 0, 1, 1);
    chk("clr_eq_state", STATE, 0);
    chk("clr_eq_a", A_DATA, 0);
    chk("clr_eq_done", DONE, 0);
    idle();
    chk("clr_eq_done2", DONE, 0);

    // Reset during S_CALC
    dig(5);
    step(0, 0, 0, 1, 0, 0);
    dig(3);
    step(0, 0, 0, 0, 1, 0);
    chk("pre_rst_calc", STATE, 2);
    RST = 1;
    idle();
    RST = 0;
    chk("rst_calc_state", STATE, 0);
    chk("rst_calc_done", DONE, 0);
    chk("rst_calc_a", A_DATA, 0);
    chk("rst_calc_b", B_DATA, 0);
    chk("rst_calc_sub", SUB_SEL, 0);
    chk("rst_calc_disp", DISP_VAL, 0);
    idle();
    chk("rst_calc_done2", DONE, 0);

    // 9 - 9 = 0, then a new digit restarts
    dig(9);
    step(0, 0, 0, 1, 0, 0);
    dig(9);
    step(0, 0, 0, 0, 1, 0);
    idle();
    chk("zero_done", DONE, 1);
    chk("zero_disp", DISP_VAL, 0);
    chk("zero_neg", DISP_NEG, 0);
    dig(2);
    chk("restart_state", STATE, 0);
    chk("restart_a", A_DATA, 6'b000010);
    chk("restart_sub", SUB_SEL, 0);
    chk("restart_b", B_DATA, 6'b000000);
    chk("restart_disp", DISP_VAL, 2);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
